inv_shift_rows_stage: RTL
=========================

# inv_shift_rows_stage

Pipelined AES InvShiftRows stage for the decryption datapath: it undoes the encrypt-side byte rotation of each 32-bit row word of the 128-bit state. Sits between the inverse-round key-add and InvSubBytes stages. Uses a valid/ready handshake with a side-band tag, so stalls from downstream decryption stages back-pressure cleanly instead of relying on free-running registers.

## Interface

Parameters:

- TAG_W, default 4: width of the side-band tag (round index or stream ID) carried alongside each state.

Ports:

- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of buffered states; has priority over the handshake.
- in_valid  in  1  in_src/in_tag valid.
- in_ready  out  1  stage can accept this cycle.
- in_src  in  128  state, layout {row3, row2, row1, row0} = [127:96], [95:64], [63:32], [31:0].
- in_tag  in  TAG_W  tag for in_src.
- out_valid  out  1  out_result/out_tag valid.
- out_ready  in  1  downstream accepts.
- out_result  out  128  inverse-shifted state, same layout.
- out_tag  out  TAG_W  tag of out_result.
- occupancy  out  2  number of states held (0..2).

## Operation

- Transform (purely per-word, no cross-word mixing):
  - row3' = row3
  - row2' = {row2[7:0], row2[31:8]} (rotate right 8)
  - row1' = {row1[15:0], row1[31:16]} (rotate 16)
  - row0' = {row0[23:0], row0[31:24]} (rotate left 8)
- Transform is applied on entry; the buffer stores transformed data and tag together.
- Accept when in_valid && in_ready. Deliver when out_valid && out_ready.
- Order preserved: FIFO, no reordering, no drops except via flush or reset.
- Simultaneous accept and deliver: occupancy unchanged; new state queued behind any held state.
- flush = 1: occupancy becomes 0 at the next edge. in_ready = 0 that cycle, so no input is accepted. A delivery shown that cycle is not counted as consumed by the stage, but it is discarded anyway.
- reset asserted: occupancy = 0, out_valid = 0, out_result = 0, out_tag = 0, in_ready = 0, all immediately. in_ready rises in the first cycle after reset deasserts. Reset mid-stream discards all held states.
- Data/tag outputs hold their last value when out_valid = 0. They are not required to be zero except after reset.

## Timing

- Latency: a state accepted at edge N is presented on out_valid/out_result after edge N.
- Throughput: 1 state/cycle sustained while out_ready = 1.
- out_valid, out_result, out_tag and occupancy are driven directly from registers.
- With INV_SR_SKID_EN (2-entry buffer):
  - in_ready = (occupancy != 2) && !flush.
  - No combinational path from out_ready to in_ready.
- Without it (1-entry register):
  - in_ready = (!out_valid || out_ready) && !flush, a combinational path from out_ready.
  - occupancy never exceeds 1.
- Full (2) with out_ready = 1: in_ready stays 0 that cycle. The next cycle occupancy = 1 and in_ready = 1.
- Empty: out_valid = 0, and out_ready is ignored.

## Configuration

- INV_SR_SKID_EN defined:
  - 2-entry skid buffer; in_ready is fully registered.
  - occupancy ranges 0..2.
- Undefined:
  - single output register; in_ready depends combinationally on out_ready.
  - occupancy ranges 0..1.
- Transform, latency, ordering and flush/reset behaviour are identical in both builds.

## Test plan

- Vector check: in_src = 00112233_44556677_8899AABB_CCDDEEFF, in_tag = 5, out_ready = 1 -> one cycle later out_result = 00112233_77445566_AABB8899_DDEEFFCC, out_tag = 5.
- Round trip: 1000 random states passed through an encrypt-side forward ShiftRows model and then this block -> every output equals the original state, and tags arrive in order.
- Back-pressure: out_ready = 0, 3 back-to-back inputs:
  - skid build: occupancy reaches 2, in_ready = 0, third input held.
  - non-skid build: occupancy 1.
  - Then out_ready = 1: all states drain in order with no loss or duplication.
- Simultaneous: occupancy = 1, in_valid = out_ready = 1 for 10 cycles -> occupancy stays 1 and one output per cycle.
- Flush: occupancy = 2 plus in_valid = 1 with flush = 1 -> in_ready = 0, next cycle occupancy = 0 and out_valid = 0, input not accepted.
- Reset mid-stream: assert reset between clock edges with occupancy = 2 -> out_valid, out_result, out_tag, occupancy and in_ready go to 0 immediately; in_ready = 1 the first cycle after release.

Source files
------------

// File: rtl/inv_shift_rows_stage.sv
// inv_shift_rows_stage: AES InvShiftRows pipeline stage with valid/ready handshake and side-band tag.
// Optional INV_SR_SKID_EN selects a 2-entry skid buffer; rev 1.0.
`default_nettype none
`timescale 1ns/1ps

module inv_shift_rows_stage #(
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       occupancy
);

  function automatic logic [127:0] inv_rows(input logic [127:0] s);
    return {s[127:96], s[71:64], s[95:72], s[47:32], s[63:48], s[23:0], s[31:24]};
  endfunction

  logic [127:0]     r_head_data;
  logic [TAG_W-1:0] r_head_tag;
  logic [1:0]       r_occ;
  logic             r_valid;

  logic [127:0]     w_in_data;
  logic             w_acc;
  logic             w_del;
  logic [1:0]       w_occ_nxt;
  logic             w_load_head;

  assign w_in_data = inv_rows(in_src);
  assign w_acc     = in_valid && in_ready;
  assign w_del     = r_valid && out_ready;

`ifdef INV_SR_SKID_EN
  logic [127:0]     r_tail_data;
  logic [TAG_W-1:0] r_tail_tag;
  logic             w_load_tail;
  logic             w_head_from_tail;

  assign in_ready = (r_occ != 2'd2) && !flush && !reset;

  always_comb begin
    w_occ_nxt        = r_occ;
    w_load_head      = 1'b0;
    w_load_tail      = 1'b0;
    w_head_from_tail = 1'b0;
    if (flush) begin
      w_occ_nxt = 2'd0;
    end else begin
      case (r_occ)
        2'd0: begin
          if (w_acc) begin
            w_load_head = 1'b1;
            w_occ_nxt   = 2'd1;
          end
        end
        2'd1: begin
          if (w_acc && w_del) begin
            w_load_head = 1'b1;
          end else if (w_acc) begin
            w_load_tail = 1'b1;
            w_occ_nxt   = 2'd2;
          end else if (w_del) begin
            w_occ_nxt = 2'd0;
          end
        end
        default: begin
          // Full: input is blocked, so only the tail can advance.
          if (w_del) begin
            w_head_from_tail = 1'b1;
            w_occ_nxt        = 2'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tail_data <= '0;
      r_tail_tag  <= '0;
    end else if (w_load_tail) begin
      r_tail_data <= w_in_data;
      r_tail_tag  <= in_tag;
    end
  end
`else
  // Single register: a slot frees up in the same cycle downstream takes the head.
  assign in_ready = (!r_valid || out_ready) && !flush && !reset;

  always_comb begin
    w_occ_nxt   = r_occ;
    w_load_head = 1'b0;
    if (flush) begin
      w_occ_nxt = 2'd0;
    end else if (w_acc) begin
      w_load_head = 1'b1;
      w_occ_nxt   = 2'd1;
    end else if (w_del) begin
      w_occ_nxt = 2'd0;
    end
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_occ       <= 2'd0;
      r_valid     <= 1'b0;
      r_head_data <= '0;
      r_head_tag  <= '0;
    end else begin
      r_occ   <= w_occ_nxt;
      r_valid <= (w_occ_nxt != 2'd0);
      if (w_load_head) begin
        r_head_data <= w_in_data;
        r_head_tag  <= in_tag;
      end
`ifdef INV_SR_SKID_EN
      else if (w_head_from_tail) begin
        r_head_data <= r_tail_data;
        r_head_tag  <= r_tail_tag;
      end
`endif
    end
  end

  assign out_valid  = r_valid;
  assign out_result = r_head_data;
  assign out_tag    = r_head_tag;
  assign occupancy  = r_occ;

endmodule

`default_nettype wire
